// File: rtl/ejercicio_1_pkg.sv
// ejercicio_1_pkg: shared constants and the carry (majority) function for the adder slice.
package ejercicio_1_pkg;
    localparam int unsigned DEFAULT_WIDTH = 1;
    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction
endpackage

// File: rtl/ejercicio_1_if.sv
// ejercicio_1_if: operand/result bundle of the adder; ovf/ovf_q exist only with EJERCICIO_1_OVERFLOW_EN.
interface ejercicio_1_if
    import ejercicio_1_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();
    logic [WIDTH-1:0] a, b, sum, sum_q;
    logic             cin, co, co_q;
`ifdef EJERCICIO_1_OVERFLOW_EN
    logic             ovf, ovf_q;
    modport master (output a, b, cin, input sum, co, sum_q, co_q, ovf, ovf_q);
    modport slave  (input a, b, cin, output sum, co, sum_q, co_q, ovf, ovf_q);
`else
    modport master (output a, b, cin, input sum, co, sum_q, co_q);
    modport slave  (input a, b, cin, output sum, co, sum_q, co_q);
`endif
endinterface

// File: rtl/ejercicio_1_fa.sv
// ejercicio_1_fa: 1-bit combinational full adder cell.
module ejercicio_1_fa
    import ejercicio_1_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = maj(a, b, ci);
endmodule

// File: rtl/ejercicio_1.sv
// ejercicio_1: WIDTH-bit ripple-carry adder with a one-cycle registered copy of the result.
// Optional signed-overflow flag (ovf/ovf_q) enabled by EJERCICIO_1_OVERFLOW_EN.
module ejercicio_1
    import ejercicio_1_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input logic          clk,
    input logic          rst_n,
    ejercicio_1_if.slave bus
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;
    assign c[0] = bus.cin;
    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_fa
            ejercicio_1_fa u_fa (.a(bus.a[i]), .b(bus.b[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
        end
    endgenerate
    assign bus.sum = s;
    assign bus.co  = c[WIDTH];
`ifdef EJERCICIO_1_OVERFLOW_EN
    // carry into MSB differs from carry out of MSB exactly on signed overflow
    assign bus.ovf = c[WIDTH] ^ c[WIDTH-1];
`endif
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.sum_q <= '0;
            bus.co_q  <= 1'b0;
`ifdef EJERCICIO_1_OVERFLOW_EN
            bus.ovf_q <= 1'b0;
`endif
        end else begin
            bus.sum_q <= s;
            bus.co_q  <= c[WIDTH];
`ifdef EJERCICIO_1_OVERFLOW_EN
            bus.ovf_q <= bus.ovf;
`endif
        end
    end
endmodule

// File: tb/tb_ejercicio_1.sv
// tb_ejercicio_1: directed checks of ejercicio_1 at WIDTH=1 and WIDTH=4 (ovf checks with EJERCICIO_1_OVERFLOW_EN).
module tb_ejercicio_1;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ejercicio_1_if #(.WIDTH(1)) if1 ();
    ejercicio_1_if #(.WIDTH(4)) if4 ();
    ejercicio_1 #(.WIDTH(1)) d1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    ejercicio_1 #(.WIDTH(4)) d4 (.clk(clk), .rst_n(rst_n), .bus(if4));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [2:0] vec [8] = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b001, 3'b011, 3'b101, 3'b111};
    logic       sum_col [8] = '{0, 1, 1, 0, 1, 0, 0, 1};
    logic       co_col  [8] = '{0, 0, 0, 1, 0, 1, 1, 1};

    initial begin
        logic [4:0] e;
        logic [4:0] eq;
        if1.a = 1'b0; if1.b = 1'b0; if1.cin = 1'b0;
        if4.a = 4'h0; if4.b = 4'h0; if4.cin = 1'b0;
        for (int k = 0; k < 8; k++) begin
            {if1.a, if1.b, if1.cin} = vec[k];
            #1;
            chk($sformatf("exh_sum_%03b", vec[k]), if1.sum, sum_col[k]);
            chk($sformatf("exh_co_%03b", vec[k]), if1.co, co_col[k]);
            #9;
        end
        @(negedge clk);
        rst_n = 1'b0; if1.a = 1'b1; if1.b = 1'b1; if1.cin = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sum_q", if1.sum_q, 0);
        chk("rst_co_q", if1.co_q, 0);
        chk("rst_sum", if1.sum, 1);
        chk("rst_co", if1.co, 1);
        chk("rst_sum_q4", if4.sum_q, 0);
        @(negedge clk);
        rst_n = 1'b1; if1.a = 1'b1; if1.b = 1'b0; if1.cin = 1'b0;
        #1;
        chk("lat_sum_now", if1.sum, 1);
        chk("lat_sum_q_before", if1.sum_q, 0);
        @(posedge clk);
        #1;
        chk("lat_sum_q_after", if1.sum_q, 1);
        chk("lat_co_q_after", if1.co_q, 0);
        @(negedge clk);
        if4.a = 4'hF; if4.b = 4'h0; if4.cin = 1'b1;
        #1;
        chk("w4_wrap_sum", if4.sum, 4'h0);
        chk("w4_wrap_co", if4.co, 1);
        @(posedge clk);
        #1;
        chk("w4_wrap_sum_q", if4.sum_q, 4'h0);
        chk("w4_wrap_co_q", if4.co_q, 1);
        @(negedge clk);
        if4.a = 4'h7; if4.b = 4'h8; if4.cin = 1'b0;
        #1;
        chk("w4_78_sum", if4.sum, 4'hF);
        chk("w4_78_co", if4.co, 0);
        if4.a = 4'hF; if4.b = 4'hF; if4.cin = 1'b1;
        #1;
        chk("w4_ones_sum", if4.sum, 4'hF);
        chk("w4_ones_co", if4.co, 1);
`ifdef EJERCICIO_1_OVERFLOW_EN
        @(negedge clk);
        if4.a = 4'h7; if4.b = 4'h1; if4.cin = 1'b0;
        if1.a = 1'b1; if1.b = 1'b1; if1.cin = 1'b0;
        #1;
        chk("ovf_71_sum", if4.sum, 4'h8);
        chk("ovf_71_ovf", if4.ovf, 1);
        chk("ovf_w1_ovf", if1.ovf, 1);
        @(posedge clk);
        #1;
        chk("ovf_71_ovf_q", if4.ovf_q, 1);
        @(negedge clk);
        if4.a = 4'hF; if4.b = 4'h1; if4.cin = 1'b0;
        if1.a = 1'b1; if1.b = 1'b1; if1.cin = 1'b1;
        #1;
        chk("ovf_F1_sum", if4.sum, 4'h0);
        chk("ovf_F1_co", if4.co, 1);
        chk("ovf_F1_ovf", if4.ovf, 0);
        chk("ovf_w1_111", if1.ovf, 0);
        @(posedge clk);
        #1;
        chk("ovf_F1_ovf_q", if4.ovf_q, 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("ovf_rst_q", if4.ovf_q, 0);
        rst_n = 1'b1;
`endif
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if4.a = 4'(k * 5 + 3); if4.b = 4'(k * 11 + 6); if4.cin = k[0];
            rst_n = (k != 6);
            e = 5'(if4.a) + 5'(if4.b) + 5'(if4.cin);
            eq = rst_n ? e : 5'd0;
            #1;
            chk($sformatf("mid_sum_%0d", k), {if4.co, if4.sum}, e);
            @(posedge clk);
            #1;
            chk($sformatf("mid_reg_%0d", k), {if4.co_q, if4.sum_q}, eq);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
